abl17_adder_fault_sequencer: RTL and testbench

Fault-campaign sequencer for the carry-lookahead adder pair: a golden 32-bit adder and a fault-injectable 32-bit adder, both driven from this block's operand outputs. It issues a programmable number of pseudo-random operand vectors. While running, it holds the selected carry-flip controls on the faulty adder. It compares the two sums one cycle later and reports the mismatch count and the first failing vector index. It sits directly upstream of both adders, feeding them, and directly downstream, consuming their sums.

---
 rtl/abl17_adder_fault_sequencer.sv | 161 ++++++++++++++++
 tb/tb_abl17_adder_fault_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/abl17_adder_fault_sequencer.sv
// Fault-campaign sequencer driving a golden and a fault-injectable adder.
// Optional macro ADDER_FAULT_SYNDROME_EN builds the first-mismatch syndrome.
module abl17_adder_fault_sequencer #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2F5B
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] num_vectors,
  input  logic [1:0]  fault_mode,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_cin,
  output logic        ctrl_flip_16,
  output logic        ctrl_flip_4,
  input  logic [31:0] sum_golden,
  input  logic [31:0] sum_fault,
  output logic        busy,
  output logic        done,
  output logic [15:0] mismatch_count,
  output logic [15:0] first_mismatch_idx,
  output logic [31:0] syndrome
);

  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] lfsr;
  logic [31:0] lfsr_nx;
  logic [15:0] vec_cnt;
  logic [15:0] num_q;
  logic        last;
  logic        kick;
  logic        vld_q;
  logic        mis_q;
  logic [15:0] idx_q;

  assign lfsr_nx = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
  assign last    = (vec_cnt == num_q - 16'd1);
  assign kick    = (state == IDLE) && start;
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (num_vectors == 16'd0) ? DONE : RUN;
      end
      RUN:     if (last) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Vector generation: operands always mirror the LFSR state during RUN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr         <= 32'h0;
      vec_cnt      <= 16'd0;
      num_q        <= 16'd0;
      op_a         <= 32'h0;
      op_b         <= 32'h0;
      op_cin       <= 1'b0;
      ctrl_flip_16 <= 1'b0;
      ctrl_flip_4  <= 1'b0;
    end else if (kick && num_vectors != 16'd0) begin
      num_q        <= num_vectors;
      lfsr         <= LFSR_SEED;
      vec_cnt      <= 16'd0;
      op_a         <= LFSR_SEED;
      op_b         <= {LFSR_SEED[15:0], LFSR_SEED[31:16]};
      op_cin       <= LFSR_SEED[0] ^ LFSR_SEED[31];
      ctrl_flip_16 <= fault_mode[0];
      ctrl_flip_4  <= fault_mode[1];
    end else if (state == RUN) begin
      lfsr    <= lfsr_nx;
      vec_cnt <= vec_cnt + 16'd1;
      if (last) begin
        op_a         <= 32'h0;
        op_b         <= 32'h0;
        op_cin       <= 1'b0;
        ctrl_flip_16 <= 1'b0;
        ctrl_flip_4  <= 1'b0;
      end else begin
        op_a   <= lfsr_nx;
        op_b   <= {lfsr_nx[15:0], lfsr_nx[31:16]};
        op_cin <= lfsr_nx[0] ^ lfsr_nx[31];
      end
    end
  end

  // Compare stage: snapshot of the vector currently on the adders
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      mis_q <= 1'b0;
      idx_q <= 16'd0;
    end else begin
      vld_q <= (state == RUN);
      mis_q <= (state == RUN) && (sum_golden != sum_fault);
      idx_q <= vec_cnt;
    end
  end

  // Accumulate stage; a start clears results (vld_q is low in IDLE)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_count     <= 16'd0;
      first_mismatch_idx <= 16'hFFFF;
    end else if (kick) begin
      mismatch_count     <= 16'd0;
      first_mismatch_idx <= 16'hFFFF;
    end else if (vld_q && mis_q) begin
      mismatch_count <= mismatch_count + 16'd1;
      if (first_mismatch_idx == 16'hFFFF)
        first_mismatch_idx <= idx_q;
    end
  end

`ifdef ADDER_FAULT_SYNDROME_EN
  logic [31:0] syn_q;
  logic [31:0] syn_r;

  // Syndrome pipeline tracks the first mismatching vector
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      syn_q <= 32'h0;
      syn_r <= 32'h0;
    end else begin
      syn_q <= sum_golden ^ sum_fault;
      if (kick)
        syn_r <= 32'h0;
      else if (vld_q && mis_q && first_mismatch_idx == 16'hFFFF)
        syn_r <= syn_q;
    end
  end

  assign syndrome = syn_r;
`else
  assign syndrome = 32'h0;
`endif

endmodule

// File: tb/tb_abl17_adder_fault_sequencer.sv
// Scoreboard bench for abl17_adder_fault_sequencer.
// Randomized and directed campaigns against a behavioural model.
module tb_abl17_adder_fault_sequencer;

  localparam logic [31:0] SEED = 32'hACE1_2F5B;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] num_vectors;
  logic [1:0]  fault_mode;
  logic [31:0] op_a, op_b;
  logic        op_cin, ctrl_flip_16, ctrl_flip_4;
  logic [31:0] sum_golden, sum_fault;
  logic        busy, done;
  logic [15:0] mismatch_count, first_mismatch_idx;
  logic [31:0] syndrome;

  logic [31:0] inj_mask [0:127];
  int          cur_idx = 0;
  logic        vec_active = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] cnt;
    logic [15:0] idx;
    logic [31:0] syn;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;

  always #5 clock = ~clock;

  assign sum_golden = op_a + op_b + {31'b0, op_cin};
  assign sum_fault  = sum_golden ^ (vec_active ? inj_mask[cur_idx] : 32'h0);

  abl17_adder_fault_sequencer dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .start              (start),
    .num_vectors        (num_vectors),
    .fault_mode         (fault_mode),
    .op_a               (op_a),
    .op_b               (op_b),
    .op_cin             (op_cin),
    .ctrl_flip_16       (ctrl_flip_16),
    .ctrl_flip_4        (ctrl_flip_4),
    .sum_golden         (sum_golden),
    .sum_fault          (sum_fault),
    .busy               (busy),
    .done               (done),
    .mismatch_count     (mismatch_count),
    .first_mismatch_idx (first_mismatch_idx),
    .syndrome           (syndrome)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic clear_inj();
    for (int i = 0; i < 128; i++) inj_mask[i] = 32'h0;
  endtask

  // Monitor: each done pulse must match the oldest pending expectation
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        m_e = exp_q.pop_front();
        chk("mismatch_count", {16'h0, mismatch_count}, {16'h0, m_e.cnt});
        chk("first_idx", {16'h0, first_mismatch_idx}, {16'h0, m_e.idx});
        chk("syndrome", syndrome, m_e.syn);
      end
    end
  end

  function automatic exp_t model(input int n);
    exp_t e;
    e.cnt = 16'd0;
    e.idx = 16'hFFFF;
    e.syn = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (inj_mask[i] != 32'h0) begin
        if (e.cnt == 16'd0) begin
          e.idx = 16'(i);
`ifdef ADDER_FAULT_SYNDROME_EN
          e.syn = inj_mask[i];
`endif
        end
        e.cnt = e.cnt + 16'd1;
      end
    end
    return e;
  endfunction

  // Called at a negedge while the DUT idles; returns at the IDLE
  // negedge right after DONE so the next call runs back-to-back.
  task automatic campaign(input int n, input logic [1:0] fm,
                          input bit poke);
    logic [31:0] s;
    exp_q.push_back(model(n));
    num_vectors = 16'(n);
    fault_mode  = fm;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    s = SEED;
    for (int k = 1; k <= n; k++) begin
      cur_idx    = k - 1;
      vec_active = 1'b1;
      chk("op_a", op_a, s);
      chk("op_b", op_b, {s[15:0], s[31:16]});
      chk("op_cin", {31'h0, op_cin}, {31'h0, s[0] ^ s[31]});
      chk("flip16_run", {31'h0, ctrl_flip_16}, {31'h0, fm[0]});
      chk("flip4_run", {31'h0, ctrl_flip_4}, {31'h0, fm[1]});
      chk("busy_run", {31'h0, busy}, 32'h1);
      chk("done_run", {31'h0, done}, 32'h0);
      if (poke) start = 1'($urandom_range(0, 1));
      s = lfsr_step(s);
      @(negedge clock);
    end
    vec_active = 1'b0;
    if (n != 0) begin
      if (poke) start = 1'b1;
      chk("busy_drain", {31'h0, busy}, 32'h1);
      chk("op_a_drain", op_a, 32'h0);
      chk("flips_drain", {30'h0, ctrl_flip_16, ctrl_flip_4}, 32'h0);
      chk("done_drain", {31'h0, done}, 32'h0);
      @(negedge clock);
    end
    start = 1'b0;
    chk("done_pulse", {31'h0, done}, 32'h1);
    chk("busy_done", {31'h0, busy}, 32'h0);
    chk("flips_done", {30'h0, ctrl_flip_16, ctrl_flip_4}, 32'h0);
    @(negedge clock);
    chk("done_low", {31'h0, done}, 32'h0);
  endtask

  task automatic check_reset_vals();
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_op_b", op_b, 32'h0);
    chk("rst_ctl", {28'h0, op_cin, ctrl_flip_16, ctrl_flip_4, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_count", {16'h0, mismatch_count}, 32'h0);
    chk("rst_idx", {16'h0, first_mismatch_idx}, 32'h0000_FFFF);
    chk("rst_syn", syndrome, 32'h0);
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    start       = 1'b0;
    num_vectors = 16'd0;
    fault_mode  = 2'b00;
    clear_inj();
    repeat (3) @(negedge clock);
    check_reset_vals();
    reset_n = 1'b1;
    @(negedge clock);

    // Clean run, no faults
    campaign(4, 2'b00, 1'b0);

    // Single flip on vector 5, back-to-back with the previous run
    inj_mask[5] = 32'h0001_0000;
    campaign(10, 2'b01, 1'b0);
    clear_inj();

    // Mismatches on 2, 3 and the last vector 7
    inj_mask[2] = 32'h0000_0010;
    inj_mask[3] = 32'h0F00_0000;
    inj_mask[7] = 32'h8000_0001;
    campaign(8, 2'b10, 1'b0);

    // Same campaign with start pokes during RUN and DRAIN
    campaign(8, 2'b10, 1'b1);
    clear_inj();

    // Zero-length campaign
    campaign(0, 2'b11, 1'b0);

    // Abort mid-RUN
    num_vectors = 16'd100;
    fault_mode  = 2'b11;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (39) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) begin
      @(negedge clock);
      chk("abort_no_done", {31'h0, done}, 32'h0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    campaign(3, 2'b01, 1'b0);

    // Randomized campaigns
    for (int r = 0; r < 8; r++) begin
      clear_inj();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++)
        if ($urandom_range(0, 5) == 0) inj_mask[i] = $urandom | 32'h1;
      campaign(n, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clock);
    chk("pending_results", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
